// File: rtl/mod_n_stream_detector_if.sv
// mod_n_stream_detector_if: beat input and result bus of the streaming mod-N detector
interface mod_n_stream_detector_if #(
    parameter int DIVISOR        = 3,
    parameter int BITS_PER_CYCLE = 1,
    parameter int MAX_BEATS      = 255
);
    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(MAX_BEATS + 1);
    logic                      in_valid;
    logic [BITS_PER_CYCLE-1:0] in_data;
    logic                      in_first;
    logic                      in_last;
    logic [RW-1:0]             rem_o;
    logic                      div_o;
    logic [CW-1:0]             beat_cnt_o;
    logic                      done_o;
    logic                      done_div_o;
    logic [RW-1:0]             done_rem_o;
    logic                      err_o;
    modport master (
        output in_valid, in_data, in_first, in_last,
        input  rem_o, div_o, beat_cnt_o, done_o, done_div_o, done_rem_o, err_o
    );
    modport slave (
        input  in_valid, in_data, in_first, in_last,
        output rem_o, div_o, beat_cnt_o, done_o, done_div_o, done_rem_o, err_o
    );
endinterface

// File: rtl/mod_n_stream_detector.sv
// mod_n_stream_detector: running remainder modulo DIVISOR of an MSB-first beat stream
module mod_n_stream_detector #(
    parameter int DIVISOR        = 3,
    parameter int BITS_PER_CYCLE = 1,
    parameter int MAX_BEATS      = 255
) (
    input logic                    clk,
    input logic                    reset,
    mod_n_stream_detector_if.slave bus
);
    localparam int RW = $clog2(DIVISOR);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [RW:0]   DIV  = (RW + 1)'(DIVISOR);
    localparam logic [CW-1:0] MAXB = CW'(MAX_BEATS);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t        state, state_next;
    logic          accept, fire_done, fire_err;
    logic [RW:0]   acc;
    logic [RW-1:0] rem_next, rem_q, done_rem_q;
    logic [CW-1:0] cnt_q;
    logic          div_q, done_q, done_div_q, err_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_comb state_next = accept ? (bus.in_last ? IDLE : ACTIVE) : state;
    // err covers both a stray non-first beat in IDLE and a restart in ACTIVE
    always_comb begin
        accept    = bus.in_valid && (bus.in_first || state == ACTIVE);
        fire_done = accept && bus.in_last;
        fire_err  = bus.in_valid && (bus.in_first == (state == ACTIVE));
    end
    // 2r+1 < 2*DIVISOR, so one conditional subtract per bit keeps r reduced
    always_comb begin
        acc = bus.in_first ? '0 : {1'b0, rem_q};
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            acc = {acc[RW-1:0], bus.in_data[i]};
            acc = acc >= DIV ? acc - DIV : acc;
        end
        rem_next = acc[RW-1:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q      <= '0;
            div_q      <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            done_div_q <= 1'b0;
            done_rem_q <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= fire_done;
            err_q  <= fire_err;
            if (accept) begin
                rem_q <= rem_next;
                div_q <= rem_next == '0;
                cnt_q <= bus.in_first ? CW'(1) : cnt_q == MAXB ? cnt_q : cnt_q + CW'(1);
            end
            if (fire_done) begin
                done_rem_q <= rem_next;
                done_div_q <= rem_next == '0;
            end
        end
    end
    assign bus.rem_o      = rem_q;
    assign bus.div_o      = div_q;
    assign bus.beat_cnt_o = cnt_q;
    assign bus.done_o     = done_q;
    assign bus.done_div_o = done_div_q;
    assign bus.done_rem_o = done_rem_q;
    assign bus.err_o      = err_q;
endmodule
